uart_mem_cmd_parser: RTL and testbench

- Host-side command front end that sits upstream of the instruction and data memories' debug access ports.
- Assembles UART RX bytes into memory read and write commands.
- Drives the memory-side request signals: write_mem_req, target_mem_type, target_addr, write data, rw_flag.
- Collects the 42-bit read response and serialises it, or a status byte, back to UART TX.
- Accepts commands only while the CPU is halted (enable low).

---
 rtl/uart_mem_cmd_parser_if.sv | 32 +++
 rtl/uart_mem_cmd_parser.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_mem_cmd_parser.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_cmd_parser_if.sv
// Bus bundle between the UART command parser, the UART byte streams and the
// memories' debug access ports.
interface uart_mem_cmd_parser_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        enable;
    logic        write_mem_req;
    logic        target_mem_type;
    logic [8:0]  target_addr;
    logic [31:0] wr_data;
    logic        rw_flag;
    logic [41:0] resp_data;
    logic        resp_valid;
    logic        busy;

    // parser side
    modport master (
        input  rx_data, rx_valid, tx_ready, enable, resp_data, resp_valid,
        output tx_data, tx_valid, write_mem_req, target_mem_type, target_addr,
               wr_data, rw_flag, busy
    );

    // UART / memory side
    modport slave (
        output rx_data, rx_valid, tx_ready, enable, resp_data, resp_valid,
        input  tx_data, tx_valid, write_mem_req, target_mem_type, target_addr,
               wr_data, rw_flag, busy
    );
endinterface

// File: rtl/uart_mem_cmd_parser.sv
// UART byte stream to memory debug-port command parser with byte-serialised replies.
// Optional trailing XOR checksum byte per frame when CMD_CHECKSUM_EN is defined.
module uart_mem_cmd_parser #(
    parameter int unsigned RESP_TIMEOUT = 16,
    parameter int unsigned RX_TIMEOUT   = 100000,
    parameter logic [7:0]  ACK_BYTE     = 8'hA5,
    parameter logic [7:0]  NAK_BYTE     = 8'hEE
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_mem_cmd_parser_if.master   bus
);

    localparam int unsigned RX_TW   = (RX_TIMEOUT   > 1) ? $clog2(RX_TIMEOUT)   : 1;
    localparam int unsigned RESP_TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [RX_TW-1:0]   RX_LAST   = RX_TW'(RX_TIMEOUT - 1);
    localparam logic [RESP_TW-1:0] RESP_LAST = RESP_TW'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_DATA,
`ifdef CMD_CHECKSUM_EN
        S_CHK,
`endif
        S_ISSUE,
        S_WAIT,
        S_TX
    } state_t;

`ifdef CMD_CHECKSUM_EN
    localparam state_t S_FRAME_END = S_CHK;
`else
    localparam state_t S_FRAME_END = S_ISSUE;
`endif

    state_t               state;
    logic                 cmd_rw;
    logic                 cmd_mem;
    logic [8:0]           addr_q;
    logic [31:0]          data_q;
    logic [1:0]           byte_cnt;
    logic [RX_TW-1:0]     rx_timer;
    logic [RESP_TW-1:0]   resp_timer;
    logic [47:0]          tx_buf;
    logic [2:0]           tx_cnt;

`ifdef CMD_CHECKSUM_EN
    logic [7:0]           chk;

    // Running XOR of the frame bytes; restarts with every command byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk <= 8'h00;
        end else if (bus.rx_valid) begin
            if (state == S_CMD)
                chk <= bus.rx_data;
            else if (state == S_ADDR || state == S_DATA)
                chk <= chk ^ bus.rx_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_CMD;
            cmd_rw              <= 1'b0;
            cmd_mem             <= 1'b0;
            addr_q              <= 9'h000;
            data_q              <= 32'h0000_0000;
            byte_cnt            <= 2'd0;
            rx_timer            <= '0;
            resp_timer          <= '0;
            tx_buf              <= 48'h0;
            tx_cnt              <= 3'd0;
            bus.tx_data         <= 8'h00;
            bus.tx_valid        <= 1'b0;
            bus.write_mem_req   <= 1'b0;
            bus.target_mem_type <= 1'b0;
            bus.target_addr     <= 9'h000;
            bus.wr_data         <= 32'h0000_0000;
            bus.rw_flag         <= 1'b0;
            bus.busy            <= 1'b0;
        end else begin
            bus.write_mem_req <= 1'b0;
            case (state)
                S_CMD: begin
                    if (bus.rx_valid) begin
                        cmd_rw   <= bus.rx_data[7];
                        cmd_mem  <= bus.rx_data[6];
                        addr_q   <= {bus.rx_data[0], 8'h00};
                        rx_timer <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    // Expiry wins over a byte arriving on the same cycle.
                    if (rx_timer == RX_LAST) begin
                        rx_timer <= '0;
                        bus.busy <= 1'b0;
                        state    <= S_CMD;
                    end else if (bus.rx_valid) begin
                        addr_q[7:0] <= bus.rx_data;
                        rx_timer    <= '0;
                        byte_cnt    <= 2'd0;
                        state       <= cmd_rw ? S_DATA : S_FRAME_END;
                    end else begin
                        rx_timer <= rx_timer + RX_TW'(1);
                    end
                end

                S_DATA: begin
                    if (rx_timer == RX_LAST) begin
                        rx_timer <= '0;
                        bus.busy <= 1'b0;
                        state    <= S_CMD;
                    end else if (bus.rx_valid) begin
                        data_q   <= {data_q[23:0], bus.rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        rx_timer <= '0;
                        if (byte_cnt == 2'd3)
                            state <= S_FRAME_END;
                    end else begin
                        rx_timer <= rx_timer + RX_TW'(1);
                    end
                end

`ifdef CMD_CHECKSUM_EN
                S_CHK: begin
                    if (rx_timer == RX_LAST) begin
                        rx_timer <= '0;
                        bus.busy <= 1'b0;
                        state    <= S_CMD;
                    end else if (bus.rx_valid) begin
                        rx_timer <= '0;
                        if (bus.rx_data == chk) begin
                            state <= S_ISSUE;
                        end else begin
                            tx_buf       <= {NAK_BYTE, 40'h0};
                            bus.tx_data  <= NAK_BYTE;
                            bus.tx_valid <= 1'b1;
                            tx_cnt       <= 3'd1;
                            state        <= S_TX;
                        end
                    end else begin
                        rx_timer <= rx_timer + RX_TW'(1);
                    end
                end
`endif

                S_ISSUE: begin
                    if (bus.enable) begin
                        tx_buf       <= {NAK_BYTE, 40'h0};
                        bus.tx_data  <= NAK_BYTE;
                        bus.tx_valid <= 1'b1;
                        tx_cnt       <= 3'd1;
                        state        <= S_TX;
                    end else begin
                        // Request fields are loaded together with the strobe.
                        bus.write_mem_req   <= 1'b1;
                        bus.target_mem_type <= cmd_mem;
                        bus.target_addr     <= addr_q;
                        bus.rw_flag         <= cmd_rw;
                        if (cmd_rw) begin
                            bus.wr_data  <= data_q;
                            tx_buf       <= {ACK_BYTE, 40'h0};
                            bus.tx_data  <= ACK_BYTE;
                            bus.tx_valid <= 1'b1;
                            tx_cnt       <= 3'd1;
                            state        <= S_TX;
                        end else begin
                            resp_timer <= '0;
                            state      <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (bus.resp_valid) begin
                        tx_buf       <= {6'b0, bus.resp_data};
                        bus.tx_data  <= {6'b0, bus.resp_data[41:40]};
                        bus.tx_valid <= 1'b1;
                        tx_cnt       <= 3'd6;
                        state        <= S_TX;
                    end else if (resp_timer == RESP_LAST) begin
                        tx_buf       <= {NAK_BYTE, 40'h0};
                        bus.tx_data  <= NAK_BYTE;
                        bus.tx_valid <= 1'b1;
                        tx_cnt       <= 3'd1;
                        state        <= S_TX;
                    end else begin
                        resp_timer <= resp_timer + RESP_TW'(1);
                    end
                end

                S_TX: begin
                    if (bus.tx_valid && bus.tx_ready) begin
                        if (tx_cnt == 3'd1) begin
                            bus.tx_valid <= 1'b0;
                            bus.tx_data  <= 8'h00;
                            tx_cnt       <= 3'd0;
                            bus.busy     <= 1'b0;
                            state        <= S_CMD;
                        end else begin
                            tx_buf      <= {tx_buf[39:0], 8'h00};
                            bus.tx_data <= tx_buf[39:32];
                            tx_cnt      <= tx_cnt - 3'd1;
                        end
                    end
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_CMD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_cmd_parser.sv
// Directed bench for uart_mem_cmd_parser: write/read/NAK paths, timeouts,
// TX back-pressure and asynchronous reset mid-transmit.
module tb_uart_mem_cmd_parser;

    localparam int unsigned RX_TO   = 40;
    localparam int unsigned RESP_TO = 16;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic reset;

    uart_mem_cmd_parser_if bus();

    uart_mem_cmd_parser #(
        .RESP_TIMEOUT (RESP_TO),
        .RX_TIMEOUT   (RX_TO),
        .ACK_BYTE     (8'hA5),
        .NAK_BYTE     (8'hEE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          req_cnt = 0;
    int          long_cnt = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    int          txv_cyc = 0;
    logic        req_prev = 1'b0;
    logic        txv_prev = 1'b0;
    logic        cap_mem, cap_rw;
    logic [8:0]  cap_addr;
    logic [31:0] cap_data;
    byte_q_t     tx_q;
    byte_q_t     frame;
    logic [7:0]  exp6 [6];

    // Monitor samples mid-low-phase, after the bench has settled its inputs.
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (bus.write_mem_req) begin
            req_cnt++;
            req_cyc  = cyc;
            cap_mem  = bus.target_mem_type;
            cap_rw   = bus.rw_flag;
            cap_addr = bus.target_addr;
            cap_data = bus.wr_data;
            if (req_prev) long_cnt++;
        end
        req_prev = bus.write_mem_req;
        if (bus.tx_valid && !txv_prev) txv_cyc = cyc;
        txv_prev = bus.tx_valid;
        if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (i < tx_q.size()) return tx_q[i];
        return 8'hxx;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        logic [7:0] x = 8'h00;
        foreach (frame[i]) begin
            x ^= frame[i];
            send_byte(frame[i]);
        end
`ifdef CMD_CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 64'(bus.busy), 64'd0);
    endtask

    task automatic wait_req(input int start, input int budget, input string tag);
        int n = 0;
        while (req_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(req_cnt != start), 64'd1);
    endtask

    task automatic wait_txv(input int budget, input string tag);
        int n = 0;
        while (!bus.tx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(bus.tx_valid), 64'd1);
    endtask

    initial begin
        int r0;
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        exp6 = '{8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 8'h13};
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.tx_ready   = 1'b1;
        bus.enable     = 1'b0;
        bus.resp_data  = 42'h0;
        bus.resp_valid = 1'b0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_txv",   64'(bus.tx_valid), 64'd0);
        check("rst_txd",   64'(bus.tx_data), 64'd0);
        check("rst_req",   64'(bus.write_mem_req), 64'd0);
        check("rst_addr",  64'(bus.target_addr), 64'd0);
        check("rst_wdata", 64'(bus.wr_data), 64'd0);
        check("rst_rw",    64'(bus.rw_flag), 64'd0);
        check("rst_mem",   64'(bus.target_mem_type), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // write C0 05 DE AD BE EF -> imem write, ACK
        tx_q.delete();
        r0 = req_cnt;
        frame = '{8'hC0, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame();
        wait_idle(200, "wr_idle");
        check("wr_reqs",  64'(req_cnt - r0), 64'd1);
        check("wr_pulse", 64'(long_cnt), 64'd0);
        check("wr_mem",   64'(cap_mem), 64'd1);
        check("wr_rw",    64'(cap_rw), 64'd1);
        check("wr_addr",  64'(cap_addr), 64'h005);
        check("wr_data",  64'(cap_data), 64'hDEADBEEF);
        check("wr_txn",   64'(tx_q.size()), 64'd1);
        check("wr_ack",   64'(q_at(0)), 64'hA5);
        check("wr_hold",  64'(bus.target_addr), 64'h005);

        // read 41 10 -> imem addr 0x110, six-byte response
        tx_q.delete();
        r0 = req_cnt;
        frame = '{8'h41, 8'h10};
        send_frame();
        wait_req(r0, 50, "rd_req_seen");
        @(negedge clk);
        bus.resp_data  = {1'b1, 9'h110, 32'h0000_0013};
        bus.resp_valid = 1'b1;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        wait_idle(200, "rd_idle");
        check("rd_reqs",  64'(req_cnt - r0), 64'd1);
        check("rd_rw",    64'(cap_rw), 64'd0);
        check("rd_mem",   64'(cap_mem), 64'd1);
        check("rd_addr",  64'(cap_addr), 64'h110);
        check("rd_wdata_hold", 64'(bus.wr_data), 64'hDEADBEEF);
        check("rd_txn",   64'(tx_q.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("rd_byte%0d", i), 64'(q_at(i)), 64'(exp6[i]));

        // write while CPU running -> NAK, no request
        tx_q.delete();
        r0 = req_cnt;
        bus.enable = 1'b1;
        frame = '{8'hC0, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame();
        wait_idle(200, "en_idle");
        bus.enable = 1'b0;
        check("en_reqs", 64'(req_cnt - r0), 64'd0);
        check("en_txn",  64'(tx_q.size()), 64'd1);
        check("en_nak",  64'(q_at(0)), 64'hEE);
        check("en_hold", 64'(bus.target_addr), 64'h110);

        // read with no response -> NAK exactly RESP_TO cycles after the request
        tx_q.delete();
        r0 = req_cnt;
        frame = '{8'h00, 8'h22};
        send_frame();
        wait_idle(200, "rto_idle");
        check("rto_reqs",  64'(req_cnt - r0), 64'd1);
        check("rto_mem",   64'(cap_mem), 64'd0);
        check("rto_addr",  64'(cap_addr), 64'h022);
        check("rto_delay", 64'(txv_cyc - req_cyc), 64'(RESP_TO));
        check("rto_txn",   64'(tx_q.size()), 64'd1);
        check("rto_nak",   64'(q_at(0)), 64'hEE);

        // partial frame abandoned; byte on the expiry cycle is dropped
        tx_q.delete();
        r0 = req_cnt;
        send_byte(8'hC0);
        send_byte(8'h05);
        send_byte(8'hDE);
        repeat (RX_TO - 1) @(negedge clk);
        check("rxto_before", 64'(bus.busy), 64'd1);
        send_byte(8'hFF);
        check("rxto_expired", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        check("rxto_noreq", 64'(req_cnt - r0), 64'd0);
        check("rxto_notx",  64'(tx_q.size()), 64'd0);
        frame = '{8'h40, 8'h01};
        send_frame();
        wait_idle(200, "rxto_idle");
        check("rxto_reqs", 64'(req_cnt - r0), 64'd1);
        check("rxto_rw",   64'(cap_rw), 64'd0);
        check("rxto_mem",  64'(cap_mem), 64'd1);
        check("rxto_addr", 64'(cap_addr), 64'h001);
        check("rxto_nak",  64'(q_at(0)), 64'hEE);

`ifdef CMD_CHECKSUM_EN
        // wrong checksum -> NAK, no request
        tx_q.delete();
        r0 = req_cnt;
        send_byte(8'hC0);
        send_byte(8'h05);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h00);
        wait_idle(200, "chk_idle");
        check("chk_reqs", 64'(req_cnt - r0), 64'd0);
        check("chk_nak",  64'(q_at(0)), 64'hEE);
`endif

        // back-pressure then reset mid-transmit
        tx_q.delete();
        r0 = req_cnt;
        bus.tx_ready = 1'b0;
        frame = '{8'h41, 8'h10};
        send_frame();
        wait_req(r0, 50, "bp_req_seen");
        @(negedge clk);
        bus.resp_data  = {1'b1, 9'h110, 32'h0000_0013};
        bus.resp_valid = 1'b1;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        wait_txv(20, "bp_txv");
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", 64'({bus.tx_valid, bus.tx_data}), 64'h103);
            @(negedge clk);
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        check("bp_next", 64'(bus.tx_data), 64'h10);
        check("bp_sent", 64'(tx_q.size()), 64'd1);
        check("bp_first", 64'(q_at(0)), 64'h03);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_txv",  64'(bus.tx_valid), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_txd",  64'(bus.tx_data), 64'd0);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_sent", 64'(tx_q.size()), 64'd1);
        check("post_rst_txv",  64'(bus.tx_valid), 64'd0);
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        check("post_rst_addr", 64'(bus.target_addr), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
